// File: rtl/lieat_wbu_arb.sv
// Write-back arbiter: picks one LSU/MUL-DIV/ALU completion per cycle into a
// registered write-back stage and emits retire pulses. LIEAT_WBU_RR_EN selects round-robin.
`ifndef RGIDX_SIZE
`define RGIDX_SIZE 5
`endif

module lieat_wbu_arb #(
   parameter int XLEN = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   lsu_valid,
   output logic                   lsu_ready,
   input  logic [`RGIDX_SIZE-1:0] lsu_rd,
   input  logic                   lsu_rdwen,
   input  logic [XLEN-1:0]        lsu_wdata,
   input  logic                   mdv_valid,
   output logic                   mdv_ready,
   input  logic [`RGIDX_SIZE-1:0] mdv_rd,
   input  logic                   mdv_rdwen,
   input  logic [XLEN-1:0]        mdv_wdata,
   input  logic                   alu_valid,
   output logic                   alu_ready,
   input  logic [`RGIDX_SIZE-1:0] alu_rd,
   input  logic                   alu_rdwen,
   input  logic [XLEN-1:0]        alu_wdata,
   output logic                   wb_valid,
   input  logic                   wb_ready,
   output logic                   wb_rdwen,
   output logic [`RGIDX_SIZE-1:0] wb_rd,
   output logic [XLEN-1:0]        wb_wdata,
   output logic                   remove_ena,
   output logic [1:0]             remove_op,
   output logic [`RGIDX_SIZE-1:0] wbu_dep_rd
);

   localparam logic [1:0] OP_LSU = 2'b00;
   localparam logic [1:0] OP_MDV = 2'b01;
   localparam logic [1:0] OP_ALU = 2'b11;

   logic                   valid_q, valid_d;
   logic                   rdwen_q, rdwen_d;
   logic [`RGIDX_SIZE-1:0] rd_q, rd_d;
   logic [XLEN-1:0]        wdata_q, wdata_d;
   logic [1:0]             op_q, op_d;

   logic                   accept;
   logic [2:0]             req;
   logic [2:0]             grant;
   logic                   xfer;
   logic [`RGIDX_SIZE-1:0] sel_rd;
   logic                   sel_rdwen;
   logic [XLEN-1:0]        sel_wdata;
   logic [1:0]             sel_op;

   assign accept = ~valid_q | wb_ready;
   assign req    = {alu_valid, mdv_valid, lsu_valid};
   assign xfer   = |grant;

`ifdef LIEAT_WBU_RR_EN
   // pointer: 0 = LSU first, 1 = MUL/DIV first, 2 = ALU first
   logic [1:0] ptr_q, ptr_d;

   // rotating-priority grant starting at the pointer
   always_comb begin
      grant = 3'b000;
      if (accept) begin
         unique case (ptr_q)
            2'd1: begin
               if (req[1])      grant = 3'b010;
               else if (req[2]) grant = 3'b100;
               else if (req[0]) grant = 3'b001;
            end
            2'd2: begin
               if (req[2])      grant = 3'b100;
               else if (req[0]) grant = 3'b001;
               else if (req[1]) grant = 3'b010;
            end
            default: begin
               if (req[0])      grant = 3'b001;
               else if (req[1]) grant = 3'b010;
               else if (req[2]) grant = 3'b100;
            end
         endcase
      end
   end

   // pointer moves past the winner only when a transfer happens
   always_comb begin
      ptr_d = ptr_q;
      if (grant[0])      ptr_d = 2'd1;
      else if (grant[1]) ptr_d = 2'd2;
      else if (grant[2]) ptr_d = 2'd0;
   end

   // pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= 2'd0;
      else     ptr_q <= ptr_d;
   end
`else
   // fixed priority LSU > MUL/DIV > ALU
   always_comb begin
      grant = 3'b000;
      if (accept) begin
         if (req[0])      grant = 3'b001;
         else if (req[1]) grant = 3'b010;
         else if (req[2]) grant = 3'b100;
      end
   end
`endif

   assign lsu_ready = grant[0];
   assign mdv_ready = grant[1];
   assign alu_ready = grant[2];

   // payload of the granted source
   always_comb begin
      sel_rd    = '0;
      sel_rdwen = 1'b0;
      sel_wdata = '0;
      sel_op    = OP_ALU;
      unique case (1'b1)
         grant[0]: begin
            sel_rd = lsu_rd; sel_rdwen = lsu_rdwen;
            sel_wdata = lsu_wdata; sel_op = OP_LSU;
         end
         grant[1]: begin
            sel_rd = mdv_rd; sel_rdwen = mdv_rdwen;
            sel_wdata = mdv_wdata; sel_op = OP_MDV;
         end
         grant[2]: begin
            sel_rd = alu_rd; sel_rdwen = alu_rdwen;
            sel_wdata = alu_wdata; sel_op = OP_ALU;
         end
         default: ;
      endcase
   end

   // stage next state: load on transfer, clear on retire, else hold
   always_comb begin
      valid_d = valid_q;
      rdwen_d = rdwen_q;
      rd_d    = rd_q;
      wdata_d = wdata_q;
      op_d    = op_q;
      if (xfer) begin
         valid_d = 1'b1;
         rdwen_d = sel_rdwen & (sel_rd != '0);
         rd_d    = sel_rd;
         wdata_d = sel_wdata;
         op_d    = sel_op;
      end else if (valid_q & wb_ready) begin
         valid_d = 1'b0;
         rdwen_d = 1'b0;
         rd_d    = '0;
         wdata_d = '0;
         op_d    = OP_ALU;
      end
   end

   // write-back stage registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         rdwen_q <= 1'b0;
         rd_q    <= '0;
         wdata_q <= '0;
         op_q    <= OP_ALU;
      end else begin
         valid_q <= valid_d;
         rdwen_q <= rdwen_d;
         rd_q    <= rd_d;
         wdata_q <= wdata_d;
         op_q    <= op_d;
      end
   end

   assign wb_valid   = valid_q;
   assign wb_rdwen   = rdwen_q;
   assign wb_rd      = rd_q;
   assign wb_wdata   = wdata_q;
   assign remove_ena = valid_q & wb_ready;
   assign remove_op  = op_q;
   assign wbu_dep_rd = (valid_q & rdwen_q) ? rd_q : '0;

endmodule

// File: tb/tb_lieat_wbu_arb.sv
// Directed bench for lieat_wbu_arb; expectations follow LIEAT_WBU_RR_EN
// when the bench is compiled with the same define as the design.
`ifndef RGIDX_SIZE
`define RGIDX_SIZE 5
`endif

module tb_lieat_wbu_arb;
   localparam int XLEN = 32;
   localparam int RW = `RGIDX_SIZE;

   logic clk = 1'b0;
   logic rst;
   logic lsu_valid, lsu_ready, lsu_rdwen;
   logic mdv_valid, mdv_ready, mdv_rdwen;
   logic alu_valid, alu_ready, alu_rdwen;
   logic [RW-1:0] lsu_rd, mdv_rd, alu_rd;
   logic [XLEN-1:0] lsu_wdata, mdv_wdata, alu_wdata;
   logic wb_valid, wb_ready, wb_rdwen;
   logic [RW-1:0] wb_rd, wbu_dep_rd;
   logic [XLEN-1:0] wb_wdata;
   logic remove_ena;
   logic [1:0] remove_op;

   int checks = 0;
   int errors = 0;

   lieat_wbu_arb #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
      .lsu_rdwen(lsu_rdwen), .lsu_wdata(lsu_wdata),
      .mdv_valid(mdv_valid), .mdv_ready(mdv_ready), .mdv_rd(mdv_rd),
      .mdv_rdwen(mdv_rdwen), .mdv_wdata(mdv_wdata),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
      .alu_rdwen(alu_rdwen), .alu_wdata(alu_wdata),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rdwen(wb_rdwen),
      .wb_rd(wb_rd), .wb_wdata(wb_wdata),
      .remove_ena(remove_ena), .remove_op(remove_op),
      .wbu_dep_rd(wbu_dep_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rdy(input string tag, input logic [2:0] exp);
      chk(tag, {61'd0, alu_ready, mdv_ready, lsu_ready}, {61'd0, exp});
   endtask

   logic [2:0] rr_rdy [4];
   logic [1:0] rr_op  [4];

   initial begin
`ifdef LIEAT_WBU_RR_EN
      rr_rdy[0] = 3'b001; rr_rdy[1] = 3'b010;
      rr_rdy[2] = 3'b100; rr_rdy[3] = 3'b001;
      rr_op[0] = 2'b00; rr_op[1] = 2'b01;
      rr_op[2] = 2'b11; rr_op[3] = 2'b00;
`else
      for (int i = 0; i < 4; i++) begin
         rr_rdy[i] = 3'b001;
         rr_op[i] = 2'b00;
      end
`endif
      rst = 1'b1;
      wb_ready = 1'b0;
      lsu_valid = 0; mdv_valid = 0; alu_valid = 0;
      lsu_rd = '0; mdv_rd = '0; alu_rd = '0;
      lsu_rdwen = 0; mdv_rdwen = 0; alu_rdwen = 0;
      lsu_wdata = '0; mdv_wdata = '0; alu_wdata = '0;
      #2;
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_wb_rd", 64'(wb_rd), 64'd0);
      chk("rst_remove_op", 64'(remove_op), 64'd3);
      chk("rst_dep_rd", 64'(wbu_dep_rd), 64'd0);
      edge1();
      rst = 1'b0;
      edge1();

      // single ALU result
      wb_ready = 1'b1;
      alu_valid = 1; alu_rd = 5; alu_rdwen = 1;
      alu_wdata = 32'hA5A5_0001;
      #1;
      chk_rdy("alu_grant", 3'b100);
      edge1();
      alu_valid = 0;
      #1;
      chk("alu_wb_valid", 64'(wb_valid), 64'd1);
      chk("alu_wb_rd", 64'(wb_rd), 64'd5);
      chk("alu_wdata", 64'(wb_wdata), 64'hA5A5_0001);
      chk("alu_wb_rdwen", 64'(wb_rdwen), 64'd1);
      chk("alu_rm_ena", 64'(remove_ena), 64'd1);
      chk("alu_rm_op", 64'(remove_op), 64'd3);
      chk("alu_dep_rd", 64'(wbu_dep_rd), 64'd5);
      chk_rdy("alu_no_rdy", 3'b000);
      edge1();
      chk("alu_drain", 64'(wb_valid), 64'd0);
      chk("alu_drain_rm", 64'(remove_ena), 64'd0);
      chk("alu_drain_dep", 64'(wbu_dep_rd), 64'd0);

      // all three valid continuously
      lsu_valid = 1; lsu_rd = 1; lsu_rdwen = 1; lsu_wdata = 32'h11;
      mdv_valid = 1; mdv_rd = 2; mdv_rdwen = 1; mdv_wdata = 32'h22;
      alu_valid = 1; alu_rd = 3; alu_rdwen = 1; alu_wdata = 32'h33;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk_rdy($sformatf("arb_rdy%0d", k), rr_rdy[k]);
         edge1();
         chk($sformatf("arb_rm%0d", k), 64'(remove_ena), 64'd1);
         chk($sformatf("arb_op%0d", k), 64'(remove_op), 64'(rr_op[k]));
      end
      lsu_valid = 0; mdv_valid = 0; alu_valid = 0;
      edge1();
      chk("arb_drain", 64'(wb_valid), 64'd0);

      // stall with MUL/DIV result held
      mdv_valid = 1; mdv_rd = 9; mdv_rdwen = 1; mdv_wdata = 32'hDEAD_0009;
      #1;
      chk_rdy("mdv_grant", 3'b010);
      edge1();
      mdv_valid = 0;
      wb_ready = 0;
      lsu_valid = 1; lsu_rd = 3; lsu_rdwen = 1; lsu_wdata = 32'h3;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("stall_v%0d", k), 64'(wb_valid), 64'd1);
         chk($sformatf("stall_rd%0d", k), 64'(wb_rd), 64'd9);
         chk($sformatf("stall_rm%0d", k), 64'(remove_ena), 64'd0);
         chk_rdy($sformatf("stall_rdy%0d", k), 3'b000);
         edge1();
      end
      lsu_valid = 0;
      wb_ready = 1;
      #1;
      chk("stall_rm", 64'(remove_ena), 64'd1);
      chk("stall_op", 64'(remove_op), 64'd1);
      chk("stall_wdata", 64'(wb_wdata), 64'hDEAD_0009);
      edge1();
      chk("stall_drain", 64'(wb_valid), 64'd0);
      chk("stall_drain_rm", 64'(remove_ena), 64'd0);

      // rd == 0 suppresses write enable
      lsu_valid = 1; lsu_rd = 0; lsu_rdwen = 1; lsu_wdata = 32'h77;
      edge1();
      lsu_valid = 0;
      #1;
      chk("x0_valid", 64'(wb_valid), 64'd1);
      chk("x0_rdwen", 64'(wb_rdwen), 64'd0);
      chk("x0_dep", 64'(wbu_dep_rd), 64'd0);
      chk("x0_rm", 64'(remove_ena), 64'd1);
      chk("x0_op", 64'(remove_op), 64'd0);
      edge1();

      // reset while a MUL/DIV result is held
      mdv_valid = 1; mdv_rd = 7; mdv_rdwen = 1; mdv_wdata = 32'h7;
      edge1();
      mdv_valid = 0;
      wb_ready = 0;
      #1;
      chk("mrst_pre", 64'(wb_valid), 64'd1);
      rst = 1;
      #1;
      chk("mrst_valid", 64'(wb_valid), 64'd0);
      chk("mrst_rd", 64'(wb_rd), 64'd0);
      chk("mrst_wdata", 64'(wb_wdata), 64'd0);
      chk("mrst_op", 64'(remove_op), 64'd3);
      chk("mrst_dep", 64'(wbu_dep_rd), 64'd0);
      edge1();
      rst = 0;
      wb_ready = 1;
      #1;
      chk("mrst_rm0", 64'(remove_ena), 64'd0);
      edge1();
      chk("mrst_rm1", 64'(remove_ena), 64'd0);
      chk("mrst_v1", 64'(wb_valid), 64'd0);

      // back-to-back LSU then ALU
      lsu_valid = 1; lsu_rd = 4; lsu_rdwen = 1; lsu_wdata = 32'h44;
      #1;
      chk_rdy("b2b_l_rdy", 3'b001);
      edge1();
      lsu_valid = 0;
      alu_valid = 1; alu_rd = 6; alu_rdwen = 1; alu_wdata = 32'h66;
      #1;
      chk("b2b_rm0", 64'(remove_ena), 64'd1);
      chk("b2b_op0", 64'(remove_op), 64'd0);
      chk_rdy("b2b_a_rdy", 3'b100);
      edge1();
      alu_valid = 0;
      #1;
      chk("b2b_rm1", 64'(remove_ena), 64'd1);
      chk("b2b_op1", 64'(remove_op), 64'd3);
      chk("b2b_rd1", 64'(wb_rd), 64'd6);
      edge1();
      chk("b2b_drain", 64'(wb_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
